// File: rtl/div_pkg.sv
// Shared types and constants for the keypad-driven divider front end.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam logic [3:0] ERR_NIBBLE = 4'hE;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERR
    } state_e;

    function automatic int hex_digits(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/operand_entry_fsm.sv
// Collects hex operands from key events, runs one division with a timeout
// and drives the value/mask pair for the 7-segment multiplexer.
module operand_entry_fsm
    import div_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    input  logic                           div_done,
    input  logic [WIDTH-1:0]               quotient,
    input  logic [WIDTH-1:0]               remainder,
    output logic [WIDTH-1:0]               a_bin,
    output logic [WIDTH-1:0]               b_bin,
    output logic                           div_start,
    output logic                           busy,
    output logic                           err,
    output logic [2*WIDTH-1:0]             disp_val,
    output logic [2*hex_digits(WIDTH)-1:0] disp_mask
);

    localparam int N  = hex_digits(WIDTH);
    localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // key_valid is a one-cycle qualifier with no backpressure; div_start is a
    // one-cycle request and div_done is only honoured while in WAIT.
    state_e            state, nxt_state;
    logic [CW-1:0]     cnt, nxt_cnt;
    logic [TW-1:0]     timer, nxt_timer, timer_inc;
    logic [WIDTH-1:0]  q_reg, r_reg, nxt_q, nxt_r, nxt_a, nxt_b;
    logic [WIDTH-1:0]  shift_a, shift_b;
    logic [2*WIDTH-1:0] nxt_disp;
    logic [2*N-1:0]    nxt_mask;
    int                entered;

    assign shift_a   = (a_bin << 4) | WIDTH'(key_code);
    assign shift_b   = (b_bin << 4) | WIDTH'(key_code);
    assign timer_inc = timer + TW'(1);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_timer = timer;
        nxt_a     = a_bin;
        nxt_b     = b_bin;
        nxt_q     = q_reg;
        nxt_r     = r_reg;
        case (state)
            ENTER_A: if (key_valid) begin
                nxt_a = shift_a;
                if (cnt == CW'(N - 1)) begin
                    nxt_cnt   = '0;
                    nxt_state = ENTER_B;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            ENTER_B: if (key_valid) begin
                nxt_b = shift_b;
                if (cnt == CW'(N - 1)) begin
                    nxt_cnt   = '0;
                    nxt_state = (shift_b == '0) ? ERR : START;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            START: begin
                nxt_timer = '0;
                nxt_state = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    nxt_q     = quotient;
                    nxt_r     = remainder;
                    nxt_state = SHOW;
                end else if (timer_inc == TW'(TIMEOUT - 1)) begin
                    nxt_state = ERR;
                end else begin
                    nxt_timer = timer_inc;
                end
            end
            SHOW, ERR: if (key_valid) begin
                // The first key of a new operation is already digit one of A.
                nxt_a     = WIDTH'(key_code);
                nxt_b     = '0;
                nxt_state = (N == 1) ? ENTER_B : ENTER_A;
                nxt_cnt   = (N == 1) ? CW'(0) : CW'(1);
            end
            default: nxt_state = ENTER_A;
        endcase
    end

    // Display is derived from next-state values so it registers alongside them.
    always_comb begin
        entered  = 2 * N;
        nxt_mask = '0;
        nxt_disp = {nxt_a, nxt_b};
        if (nxt_state == ENTER_A) entered = int'(nxt_cnt);
        if (nxt_state == ENTER_B) entered = N + int'(nxt_cnt);
        if (nxt_state == SHOW)    nxt_disp = {nxt_q, nxt_r};
        if (nxt_state == ERR)     nxt_disp = {(2 * N){ERR_NIBBLE}};
        for (int i = 0; i < 2 * N; i++) begin
            nxt_mask[i] = ((2 * N - 1 - i) < entered);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTER_A;
            cnt       <= '0;
            timer     <= '0;
            a_bin     <= '0;
            b_bin     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            div_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            disp_val  <= '0;
            disp_mask <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            timer     <= nxt_timer;
            a_bin     <= nxt_a;
            b_bin     <= nxt_b;
            q_reg     <= nxt_q;
            r_reg     <= nxt_r;
            div_start <= (nxt_state == START);
            busy      <= (nxt_state == START) || (nxt_state == WAIT);
            err       <= (nxt_state == ERR);
            disp_val  <= nxt_disp;
            disp_mask <= nxt_mask;
        end
    end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Self-checking bench for operand_entry_fsm with a behavioural divider model.
module tb_operand_entry_fsm;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] b_bin;
    logic             div_start;
    logic             busy;
    logic             err;
    logic [15:0]      disp_val;
    logic [3:0]       disp_mask;

    operand_entry_fsm #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .div_done(div_done), .quotient(quotient), .remainder(remainder),
        .a_bin(a_bin), .b_bin(b_bin), .div_start(div_start), .busy(busy),
        .err(err), .disp_val(disp_val), .disp_mask(disp_mask)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    typedef struct {
        logic [3:0]  k0, k1, k2, k3;
        int          lat;
        logic        exp_err;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Divider model: answers lat cycles into WAIT, optionally with a key in the same cycle.
    task automatic serve_div(input int lat, input logic with_key);
        @(negedge clk);
        chk("div_start_one_cycle", div_start, 0);
        chk("busy_in_wait", busy, 1);
        repeat (lat - 1) @(negedge clk);
        quotient  = (b_bin != 0) ? a_bin / b_bin : 8'hFF;
        remainder = (b_bin != 0) ? a_bin % b_bin : 8'hFF;
        div_done  = 1'b1;
        key_valid = with_key;
        key_code  = 4'hC;
        @(negedge clk);
        div_done  = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic check_show(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_mask"}, disp_mask, 4'hF);
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 1, 0);
        end else begin
            exp_v = exp_q.pop_front();
            chk({name, "_disp"}, disp_val, exp_v);
        end
    endtask

    initial begin
        tbl[0] = '{4'h4, 4'h5, 4'h0, 4'h7, 10, 1'b0, 8'h45, 8'h07, 16'h0906};
        tbl[1] = '{4'h7, 4'hE, 4'h0, 4'h9,  3, 1'b0, 8'h7E, 8'h09, 16'h0E00};
        tbl[2] = '{4'h1, 4'h2, 4'h0, 4'h0,  0, 1'b1, 8'h12, 8'h00, 16'hEEEE};
        tbl[3] = '{4'hF, 4'hF, 4'h0, 4'h1,  1, 1'b0, 8'hFF, 8'h01, 16'hFF00};
        tbl[4] = '{4'h0, 4'h3, 4'hF, 4'hF,  5, 1'b0, 8'h03, 8'hFF, 16'h0003};
        tbl[5] = '{4'h8, 4'h0, 4'h0, 4'h3,  2, 1'b0, 8'h80, 8'h03, 16'h2A02};

        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        div_done = 1'b0; quotient = '0; remainder = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_bin", a_bin, 0);
        chk("rst_b_bin", b_bin, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_disp_val", disp_val, 0);
        chk("rst_disp_mask", disp_mask, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            press(tbl[i].k0);
            chk("first_key_a", a_bin, {4'h0, tbl[i].k0});
            chk("first_key_b", b_bin, 0);
            chk("first_key_err", err, 0);
            chk("first_key_mask", disp_mask, 4'b1000);
            press(tbl[i].k1);
            chk("a_done_mask", disp_mask, 4'b1100);
            press(tbl[i].k2);
            chk("b_digit_mask", disp_mask, 4'b1110);
            chk("entry_disp", disp_val, {tbl[i].exp_a, 4'h0, tbl[i].k2});
            press(tbl[i].k3);
            exp_q.push_back(tbl[i].exp_disp);
            chk("final_a", a_bin, tbl[i].exp_a);
            chk("final_b", b_bin, tbl[i].exp_b);
            if (tbl[i].exp_err) begin
                chk("bzero_err", err, 1);
                chk("bzero_no_start", div_start, 0);
                chk("bzero_busy", busy, 0);
                chk("bzero_mask", disp_mask, 4'hF);
                exp_v = exp_q.pop_front();
                chk("bzero_disp", disp_val, exp_v);
                @(negedge clk);
                chk("bzero_still_no_start", div_start, 0);
                chk("bzero_err_held", err, 1);
            end else begin
                chk("start_pulse", div_start, 1);
                chk("start_busy", busy, 1);
                serve_div(tbl[i].lat, 1'b0);
                check_show("show");
                chk("show_a_stable", a_bin, tbl[i].exp_a);
                chk("show_b_stable", b_bin, tbl[i].exp_b);
            end
        end

        // Keys during WAIT, one coinciding with div_done, must be dropped.
        press(4'h9); press(4'h6); press(4'h0); press(4'h4);
        exp_q.push_back(16'h2502);
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'h3;
        @(negedge clk);
        key_valid = 1'b0;
        chk("wait_key_a", a_bin, 8'h96);
        chk("wait_key_b", b_bin, 8'h04);
        chk("wait_key_busy", busy, 1);
        serve_div(1, 1'b1);
        check_show("coincide");
        chk("coincide_a", a_bin, 8'h96);
        chk("coincide_b", b_bin, 8'h04);
        @(negedge clk);
        chk("coincide_key_dropped_mask", disp_mask, 4'hF);
        chk("coincide_key_dropped_disp", disp_val, 16'h2502);

        // Timeout: err rises exactly TIMEOUT cycles after the start cycle.
        press(4'h1); press(4'h2); press(4'h0); press(4'h3);
        chk("to_start", div_start, 1);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_not_yet_err", err, 0);
        chk("to_not_yet_busy", busy, 1);
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_disp", disp_val, 16'hEEEE);
        div_done = 1'b1; quotient = 8'h11; remainder = 8'h22;
        @(negedge clk);
        div_done = 1'b0;
        @(negedge clk);
        chk("late_done_err", err, 1);
        chk("late_done_disp", disp_val, 16'hEEEE);
        chk("late_done_mask", disp_mask, 4'hF);

        press(4'h3);
        chk("after_err_err", err, 0);
        chk("after_err_a", a_bin, 8'h03);
        chk("after_err_b", b_bin, 8'h00);
        chk("after_err_mask", disp_mask, 4'b1000);
        chk("after_err_disp", disp_val, 16'h0300);
        press(4'h4); press(4'h0); press(4'h1);
        exp_q.push_back(16'h3400);
        chk("after_err_start", div_start, 1);
        serve_div(4, 1'b0);
        check_show("after_err_show");

        // Reset in the middle of WAIT, then a stale done.
        press(4'h5); press(4'h5); press(4'h0); press(4'h5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_a", a_bin, 0);
        chk("midrst_b", b_bin, 0);
        chk("midrst_start", div_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_disp", disp_val, 0);
        chk("midrst_mask", disp_mask, 0);
        rst = 1'b0;
        @(negedge clk);
        div_done = 1'b1; quotient = 8'h77; remainder = 8'h66;
        @(negedge clk);
        div_done = 1'b0;
        @(negedge clk);
        chk("stale_done_mask", disp_mask, 0);
        chk("stale_done_busy", busy, 0);
        chk("stale_done_disp", disp_val, 0);
        chk("stale_done_err", err, 0);
        press(4'h2);
        chk("post_rst_a", a_bin, 8'h02);
        chk("post_rst_mask", disp_mask, 4'b1000);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Sits between the keypad scanner/debouncer and the restoring divider inside top_divisor.
- Assembles dividend A and divisor B from hex key events (MSB digit first) and rejects B=0.
- Issues a one-cycle start to the divider, then waits for completion with a timeout.
- Latches quotient/remainder and drives the value/mask pair consumed by the 7-segment multiplexer.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of 4; N=WIDTH/4 hex digits per operand.
- TIMEOUT, 1024: maximum cycles in WAIT before declaring an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; one clock domain, no other clocks.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  hex value of the pressed key; all 16 codes are digits.
- div_done  in  1  divider completion pulse/level.
- quotient  in  WIDTH  divider quotient, valid when div_done=1.
- remainder  in  WIDTH  divider remainder, valid when div_done=1.
- a_bin  out  WIDTH  dividend to divider.
- b_bin  out  WIDTH  divisor to divider.
- div_start  out  1  one-cycle start pulse.
- busy  out  1  high in START and WAIT.
- err  out  1  high in ERR.
- disp_val  out  2*WIDTH  display value; upper WIDTH bits = left digits.
- disp_mask  out  2*N  per-digit enable; bit i enables hex digit i, LSB = rightmost.

Behaviour:
- Reset (synchronous, takes priority over everything): state=ENTER_A, digit count=0, a_bin=0, b_bin=0, q_reg=0, r_reg=0, div_start=0, busy=0, err=0, disp_val=0, disp_mask=0.
- All outputs are registered.
- ENTER_A, on key_valid:
  - a_bin <= {a_bin[WIDTH-5:0], key_code}; count++.
  - On the Nth digit: count <= 0, go to ENTER_B.
- ENTER_B, on key_valid:
  - Same shift into b_bin.
  - On the Nth digit, if the resulting b_bin == 0: go to ERR, no start issued.
  - Otherwise: go to START.
- START: div_start=1 for exactly this one cycle, i.e. the cycle after the final digit's key_valid. busy=1. Timer cleared. key_valid ignored. Go to WAIT.
- WAIT:
  - busy=1; timer increments each cycle.
  - If div_done: q_reg <= quotient, r_reg <= remainder, go to SHOW.
  - Else if timer reaches TIMEOUT-1: go to ERR.
  - key_valid is ignored; when key_valid and div_done coincide, the key is dropped.
- SHOW: disp_val={q_reg,r_reg}, all mask bits set.
- ERR: err=1; disp_val all 4'hE nibbles; all mask bits set.
- Any key_valid in SHOW or ERR starts a new entry:
  - a_bin <= {0…, key_code}, b_bin <= 0, count=1, err<=0.
  - Go to ENTER_A, or straight to ENTER_B if N=1.
- Entry display: disp_val={a_bin,b_bin}; mask enables only digits already entered in the current operation (A digits from bit 2N-1 downward, then B digits).
- a_bin/b_bin hold stable from the final digit through WAIT and SHOW.
- div_done is ignored in every state except WAIT, so a stale done after reset or timeout has no effect.

Decomposition:
- Shared package div_pkg holds:
  - state enum {ENTER_A, ENTER_B, START, WAIT, SHOW, ERR};
  - default WIDTH;
  - ERR_NIBBLE=4'hE;
  - function hex_digits(WIDTH).
- Single module; the timeout counter is inline and no sub-module is warranted.

Test Plan:
- Keys 4,5,0,7 → a_bin=0x45, b_bin=0x07, div_start high exactly one cycle after key 7. Model done after 10 cycles with Q=9, R=6 → disp_val=0x0906, mask=4'hF, busy=0.
- New entry 7,E,0,9 from SHOW → a_bin=0x7E, b_bin=0x09. Done with Q=14, R=0 → disp_val=0x0E00.
- Keys 1,2,0,0 → no div_start, err=1, disp_val=0xEEEE. Next key 3 → err=0, a_bin=0x03, b_bin=0, mask=4'b1000.
- Valid entry with no div_done → err=1 exactly TIMEOUT cycles after the div_start cycle. A later div_done does not change state.
- Extra keys during WAIT, including one in the same cycle as div_done → a_bin/b_bin unchanged, SHOW reached, key dropped.
- rst asserted mid-WAIT → all outputs 0 at the next edge. A div_done pulse two cycles later is ignored; state stays ENTER_A with mask=0.
